// File: rtl/transpose_pkg.sv
// Shared types and constants for the ping-pong transpose scheduler and its banks.
package transpose_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StLoading,
    StFull,
    StDraining
  } bank_state_e;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_DRAIN = 1'b1;

  // Beat counters need at least one bit even for a 1x1 tile.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One NxN register-shift transpose bank: mode 0 shifts rows in column-wise,
// mode 1 shifts rows up towards row 0 for draining.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en_i,
  input  logic                                 mode_i,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] row_in_i,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] row0_out_o
);

  localparam int unsigned N  = SYSTOLIC_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic [DW-1:0] mat_q [N][N];
  logic [DW-1:0] mat_d [N][N];

  always_comb begin
    mat_d = mat_q;
    if (en_i) begin
      if (mode_i == MODE_LOAD) begin
        for (int i = 0; i < int'(N); i++) begin
          mat_d[i][0] = row_in_i[i*DW +: DW];
          for (int j = 1; j < int'(N); j++) begin
            mat_d[i][j] = mat_q[i][j-1];
          end
        end
      end else begin
        for (int i = 0; i < int'(N) - 1; i++) begin
          for (int j = 0; j < int'(N); j++) begin
            mat_d[i][j] = mat_q[i+1][j];
          end
        end
        for (int j = 0; j < int'(N); j++) begin
          mat_d[N-1][j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          mat_q[i][j] <= '0;
        end
      end
    end else begin
      mat_q <= mat_d;
    end
  end

  always_comb begin
    row0_out_o = '0;
    for (int j = 0; j < int'(N); j++) begin
      row0_out_o[j*DW +: DW] = mat_q[0][j];
    end
  end

endmodule

// File: rtl/transpose_pingpong_ctrl.sv
// Double-buffered NxN transpose scheduler: one bank loads while the other drains.
// Optional completed-tile counter enabled by defining TRANSPOSE_PERF_CNT_EN.
module transpose_pingpong_ctrl
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data_o,
  output logic                                 out_last_o
`ifdef TRANSPOSE_PERF_CNT_EN
  ,
  output logic [31:0]                          tile_cnt_o
`endif
);

  localparam int unsigned N    = SYSTOLIC_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned RowW = N * DW;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;

  logic            in_hs, out_hs;
  logic [1:0]      bank_en;
  logic [1:0]      bank_mode;
  logic [RowW-1:0] bank_row0 [2];
  logic [RowW-1:0] rd_row0;

  always_comb begin
    in_ready_o  = ((state_q[wr_sel_q] == StEmpty) || (state_q[wr_sel_q] == StLoading)) && !clr_i;
    out_valid_o = (state_q[rd_sel_q] == StFull) || (state_q[rd_sel_q] == StDraining);
    in_hs       = in_valid_i && in_ready_o;
    // Soft clear wins over a pending output handshake as well.
    out_hs      = out_valid_o && out_ready_i && !clr_i;
  end

  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (clr_i) begin
      state_d[0] = StEmpty;
      state_d[1] = StEmpty;
      wr_sel_d   = 1'b0;
      rd_sel_d   = 1'b0;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
    end else begin
      if (in_hs) begin
        if (wr_cnt_q == CntLast) begin
          state_d[wr_sel_q] = StFull;
          wr_cnt_d          = '0;
          wr_sel_d          = !wr_sel_q;
        end else begin
          state_d[wr_sel_q] = StLoading;
          wr_cnt_d          = wr_cnt_q + 1'b1;
        end
      end
      // Load and drain never address the same bank, so both updates can apply.
      if (out_hs) begin
        if (rd_cnt_q == CntLast) begin
          state_d[rd_sel_q] = StEmpty;
          rd_cnt_d          = '0;
          rd_sel_d          = !rd_sel_q;
        end else begin
          state_d[rd_sel_q] = StDraining;
          rd_cnt_d          = rd_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= StEmpty;
      state_q[1] <= StEmpty;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BankId = 1'(b);

    assign bank_en[b]   = (in_hs && (wr_sel_q == BankId)) || (out_hs && (rd_sel_q == BankId));
    assign bank_mode[b] = (out_hs && (rd_sel_q == BankId)) ? MODE_DRAIN : MODE_LOAD;

    transpose_bank #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SYSTOLIC_WIDTH (SYSTOLIC_WIDTH)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (bank_en[b]),
      .mode_i     (bank_mode[b]),
      .row_in_i   (in_data_i),
      .row0_out_o (bank_row0[b])
    );
  end

  // Column N-1 holds the oldest input beat, so element order is reversed on output.
  always_comb begin
    rd_row0    = bank_row0[rd_sel_q];
    out_data_o = '0;
    for (int p = 0; p < int'(N); p++) begin
      out_data_o[p*DW +: DW] = rd_row0[(int'(N) - 1 - p)*DW +: DW];
    end
    out_last_o = out_valid_o && (rd_cnt_q == CntLast);
  end

`ifdef TRANSPOSE_PERF_CNT_EN
  logic [31:0] tile_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt_q <= '0;
    end else if (out_hs && out_last_o) begin
      tile_cnt_q <= tile_cnt_q + 32'd1;
    end
  end

  assign tile_cnt_o = tile_cnt_q;
`endif

endmodule

// File: tb/tb_transpose_pingpong_ctrl.sv
// Randomized bench for transpose_pingpong_ctrl with a queue-based transpose model.
module tb_transpose_pingpong_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = N * DW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef TRANSPOSE_PERF_CNT_EN
  logic [31:0]  tile_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] part_q[$];
  logic [W-1:0] exp_q[$];
  int unsigned  tiles_done = 0;

  logic         s_in_hs, s_out_hs, s_in_ready, s_out_valid, s_last;
  logic [W-1:0] s_data;

  transpose_pingpong_ctrl #(
    .DATA_WIDTH     (DW),
    .SYSTOLIC_WIDTH (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
`ifdef TRANSPOSE_PERF_CNT_EN
    ,
    .tile_cnt_o  (tile_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row_k(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) r[i*DW +: DW] = {8'h00, 4'(k), 4'(i)};
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  // One clock: drive at negedge, sample, score against the model, advance the model.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic c);
    int           occ;
    logic         exp_rdy, exp_val, exp_last;
    logic [W-1:0] row, tmp;
    @(negedge clk);
    clr = c; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    occ      = (exp_q.size() + int'(N) - 1) / int'(N) + ((part_q.size() > 0) ? 1 : 0);
    exp_rdy  = !c && ((part_q.size() > 0) || (occ < 2));
    exp_val  = exp_q.size() > 0;
    exp_last = exp_val && ((exp_q.size() % int'(N)) == 1);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++; $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== exp_val) begin
      errors++; $display("FAIL out_valid: got %b want %b", out_valid, exp_val);
    end
    checks++;
    if (out_last !== exp_last) begin
      errors++; $display("FAIL out_last: got %b want %b", out_last, exp_last);
    end
    if (exp_val && out_valid) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL out_data: got %h want %h", out_data, exp_q[0]);
      end
    end
    s_in_ready = in_ready; s_out_valid = out_valid; s_data = out_data; s_last = out_last;
    s_in_hs  = iv && in_ready;
    s_out_hs = out_valid && ordy && !c;
    if (c) begin
      part_q.delete(); exp_q.delete();
    end else begin
      if (s_out_hs && exp_val) begin
        if (exp_last) tiles_done++;
        void'(exp_q.pop_front());
      end
      if (s_in_hs) begin
        part_q.push_back(id);
        if (part_q.size() == int'(N)) begin
          for (int r = 0; r < int'(N); r++) begin
            row = '0;
            for (int p = 0; p < int'(N); p++) begin
              tmp = part_q[p];
              row[p*DW +: DW] = tmp[r*DW +: DW];
            end
            exp_q.push_back(row);
          end
          part_q.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    part_q.delete(); exp_q.delete(); tiles_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b val=%b last=%b data=%h want 1 0 0 0",
               in_ready, out_valid, out_last, out_data);
    end
`ifdef TRANSPOSE_PERF_CNT_EN
    checks++;
    if (tile_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_tile_cnt: got %0d want 0", tile_cnt);
    end
`endif
  endtask

  task automatic test_single_tile();
    logic [W-1:0] got [4];
    logic [3:0]   lasts;
    int           n;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, row_k(k), 1'b1, 1'b0);
      if (k == 3) begin
        checks++;
        if (s_out_valid !== 1'b0) begin
          errors++; $display("FAIL early_valid: got %b want 0", s_out_valid);
        end
      end
    end
    n = 0; lasts = '0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (c == 0) begin
        checks++;
        if (s_out_valid !== 1'b1) begin
          errors++; $display("FAIL latency_valid: got %b want 1", s_out_valid);
        end
      end
      if (s_out_hs && n < 4) begin
        got[n] = s_data; lasts[n] = s_last; n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL single_rows: got %0d want 4", n);
    end
    checks++;
    if (got[1] !== 64'h0031_0021_0011_0001) begin
      errors++; $display("FAIL single_row1: got %h want 0031002100110001", got[1]);
    end
    checks++;
    if (got[3] !== 64'h0033_0023_0013_0003) begin
      errors++; $display("FAIL single_row3: got %h want 0033002300130003", got[3]);
    end
    checks++;
    if (lasts !== 4'b1000) begin
      errors++; $display("FAIL single_last: got %b want 1000", lasts);
    end
  endtask

  task automatic test_back_to_back();
    int nin, nout, drops, first, lastc;
    do_reset();
    nin = 0; nout = 0; drops = 0; first = -1; lastc = -1;
    for (int cyc = 0; cyc < 40 && nout < 12; cyc++) begin
      step(nin < 12, rand_row(), 1'b1, 1'b0);
      if (nin < 12 && !s_in_ready) drops++;
      if (s_in_hs) nin++;
      if (s_out_hs) begin
        if (first < 0) first = cyc;
        lastc = cyc; nout++;
      end
    end
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL b2b_ready_drops: got %0d want 0", drops);
    end
    checks++;
    if (nout != 12) begin
      errors++; $display("FAIL b2b_rows: got %0d want 12", nout);
    end
    checks++;
    if (lastc - first != 11) begin
      errors++; $display("FAIL b2b_bubbles: got span %0d want 11", lastc - first);
    end
`ifdef TRANSPOSE_PERF_CNT_EN
    #1;
    checks++;
    if (tile_cnt !== 32'd3) begin
      errors++; $display("FAIL b2b_tile_cnt: got %0d want 3", tile_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    int acc;
    do_reset();
    acc = 0;
    for (int s = 0; s < 10; s++) begin
      step(1'b1, rand_row(), 1'b0, 1'b0);
      if (s_in_hs) acc++;
    end
    checks++;
    if (acc != 8) begin
      errors++; $display("FAIL stall_accepted: got %0d want 8", acc);
    end
    for (int s = 0; s < 5; s++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (s_in_ready !== (s == 4)) begin
        errors++; $display("FAIL stall_release_ready[%0d]: got %b want %b", s, s_in_ready, s == 4);
      end
    end
    for (int s = 0; s < 10 && exp_q.size() > 0; s++) step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain: got %0d rows left want 0", exp_q.size());
    end
  endtask

  task automatic test_toggle();
    logic         prev_stall;
    logic [W-1:0] prev_data;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, rand_row(), 1'b0, 1'b0);
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, '0, (c % 2) == 1, 1'b0);
      if (prev_stall) begin
        checks++;
        if (s_data !== prev_data) begin
          errors++; $display("FAIL toggle_stable: got %h want %h", s_data, prev_data);
        end
      end
      prev_stall = s_out_valid && !s_out_hs;
      prev_data  = s_data;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL toggle_drain: got %0d rows left want 0", exp_q.size());
    end
  endtask

  task automatic test_clr();
    int nout;
    do_reset();
    step(1'b1, rand_row(), 1'b1, 1'b0);
    step(1'b1, rand_row(), 1'b1, 1'b0);
    step(1'b1, rand_row(), 1'b1, 1'b1);
    checks++;
    if (s_in_hs !== 1'b0) begin
      errors++; $display("FAIL clr_accept: got %b want 0", s_in_hs);
    end
    nout = 0;
    for (int k = 0; k < 4; k++) step(1'b1, row_k(k + 4), 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_out_hs) nout++;
    end
    checks++;
    if (nout != 4) begin
      errors++; $display("FAIL clr_rows: got %0d want 4", nout);
    end
    // Clear with a full tile waiting and the consumer ready.
    for (int k = 0; k < 4; k++) step(1'b1, rand_row(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_flush_valid: got %b want 0", s_out_valid);
    end
`ifdef TRANSPOSE_PERF_CNT_EN
    checks++;
    if (tile_cnt !== tiles_done) begin
      errors++; $display("FAIL clr_tile_cnt: got %0d want %0d", tile_cnt, tiles_done);
    end
`endif
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, rand_row(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    part_q.delete(); exp_q.delete(); tiles_done = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_release: got rdy=%b val=%b data=%h want 1 0 0",
               in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, rand_row(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d rows left want 0", exp_q.size());
    end
`ifdef TRANSPOSE_PERF_CNT_EN
    #1;
    checks++;
    if (tile_cnt !== tiles_done) begin
      errors++; $display("FAIL random_tile_cnt: got %0d want %0d", tile_cnt, tiles_done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_clr();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
